// File: rtl/yd_pkg.sv
// Shared YD data-bus types and width defaults.
package yd_pkg;

    localparam int unsigned YD_AW = 16;
    localparam int unsigned YD_DW = 16;

    // Type of the access granted on the RAM port in a given cycle.
    typedef enum logic [2:0] {
        GntNone,
        GntCoreRd,
        GntCoreWr,
        GntAuxRd,
        GntAuxWr
    } last_grant_e;

endpackage

// File: rtl/yd_starve_cnt.sv
// Saturating count of consecutive cycles the aux requester was left waiting.
// Raises force_grant once the aux port has waited MAX_WAIT cycles.
module yd_starve_cnt #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic a_ready,
    output logic force_grant
);

    localparam logic [7:0] MaxCnt = 8'(MAX_WAIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear on grant or idle, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!a_valid || a_ready) begin
            cnt_d = '0;
        end else if (cnt_q != MaxCnt) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Force decision is registered-count based, so it never loops through a_ready.
    always_comb begin
        force_grant = a_valid && (cnt_q == MaxCnt);
    end

endmodule

// File: rtl/yd_dbus_arbiter.sv
// Core/aux arbiter for the single-port YD data RAM. The core has priority.
// Optional starvation guard enabled by defining YD_DBUS_STARVE_EN.
module yd_dbus_arbiter
    import yd_pkg::*;
#(
    parameter int unsigned AW       = YD_AW,
    parameter int unsigned DW       = YD_DW,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_din,
    input  logic          c_we,
    output logic [DW-1:0] c_dout,
    output logic          c_stall,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    input  logic          a_we,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_din,
    output logic          m_we,
    input  logic [DW-1:0] m_dout
);

    logic          force_grant;
    logic          core_gnt;
    logic          aux_gnt;
    last_grant_e   grant_d;
    last_grant_e   last_grant_q;
    logic [DW-1:0] c_dout_q;

`ifdef YD_DBUS_STARVE_EN
    logic force_raw;

    yd_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .force_grant(force_raw)
    );

    assign force_grant = force_raw && !rst;
`else
    localparam int unsigned UnusedMaxWait = MAX_WAIT;
    assign force_grant = 1'b0;
`endif

    // Grant decision and RAM port mux; reset suppresses every grant.
    always_comb begin
        core_gnt = 1'b0;
        aux_gnt  = 1'b0;
        m_addr   = '0;
        m_din    = '0;
        m_we     = 1'b0;
        grant_d  = GntNone;
        if (rst) begin
            grant_d = GntNone;
        end else if (force_grant) begin
            aux_gnt = 1'b1;
        end else if (c_req) begin
            core_gnt = 1'b1;
        end else if (a_valid) begin
            aux_gnt = 1'b1;
        end
        if (core_gnt) begin
            m_addr  = c_addr;
            m_din   = c_din;
            m_we    = c_we;
            grant_d = c_we ? GntCoreWr : GntCoreRd;
        end else if (aux_gnt) begin
            m_addr  = a_addr;
            m_din   = a_din;
            m_we    = a_we;
            grant_d = a_we ? GntAuxWr : GntAuxRd;
        end
        a_ready = aux_gnt;
        c_stall = force_grant;
    end

    // Grant history and held core read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GntNone;
            c_dout_q     <= '0;
        end else begin
            last_grant_q <= grant_d;
            if (last_grant_q == GntCoreRd) begin
                c_dout_q <= m_dout;
            end
        end
    end

    // Route returning RAM data; a read in flight at reset is dropped.
    always_comb begin
        c_dout   = (last_grant_q == GntCoreRd && !rst) ? m_dout : c_dout_q;
        a_rvalid = (last_grant_q == GntAuxRd) && !rst;
        a_rdata  = m_dout;
    end

endmodule

// File: tb/tb_yd_dbus_arbiter.sv
// Directed bench for yd_dbus_arbiter with a behavioural synchronous RAM.
// Contention expectations follow YD_DBUS_STARVE_EN.
module tb_yd_dbus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_din;
    logic          c_we;
    logic [DW-1:0] c_dout;
    logic          c_stall;
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          a_we;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic          m_we;
    logic [DW-1:0] m_dout;

    int total = 0;
    int passed = 0;

    logic [DW-1:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_we) mem[m_addr[9:0]] <= m_din;
        m_dout <= mem[m_addr[9:0]];
    end

    yd_dbus_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .c_req   (c_req),
        .c_addr  (c_addr),
        .c_din   (c_din),
        .c_we    (c_we),
        .c_dout  (c_dout),
        .c_stall (c_stall),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_din   (a_din),
        .a_we    (a_we),
        .a_rvalid(a_rvalid),
        .a_rdata (a_rdata),
        .m_addr  (m_addr),
        .m_din   (m_din),
        .m_we    (m_we),
        .m_dout  (m_dout)
    );

    task automatic idle_inputs();
        c_req = 0; c_addr = '0; c_din = '0; c_we = 0;
        a_valid = 0; a_addr = '0; a_din = '0; a_we = 0;
    endtask

    // Finish the current cycle and move to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        c_req = 1; c_we = 1; c_addr = 16'h0005; a_valid = 1; a_we = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (m_we !== 1'b0) $display("FAIL rst_m_we got=%b want=0", m_we); else passed++;
        total++;
        if (a_ready !== 1'b0) $display("FAIL rst_a_ready got=%b want=0", a_ready); else passed++;
        next_cycle();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        total++;
        if (c_stall !== 1'b0 || a_rvalid !== 1'b0 || c_dout !== 16'h0000 || m_addr !== 16'h0000
            || m_din !== 16'h0000)
            $display("FAIL reset_values stall=%b rvalid=%b c_dout=%h m_addr=%h m_din=%h want 0",
                     c_stall, a_rvalid, c_dout, m_addr, m_din);
        else passed++;
        next_cycle();
    endtask

    task automatic test_core_only();
        c_req = 1; c_we = 1; c_addr = 16'h0010; c_din = 16'h1234;
        @(negedge clk);
        total++;
        if (m_we !== 1'b1 || m_addr !== 16'h0010 || m_din !== 16'h1234 || a_ready !== 1'b0)
            $display("FAIL core_wr m_we=%b m_addr=%h m_din=%h a_ready=%b want 1/0010/1234/0",
                     m_we, m_addr, m_din, a_ready);
        else passed++;
        next_cycle();
        c_we = 0;
        @(negedge clk);
        total++;
        if (m_we !== 1'b0 || m_addr !== 16'h0010 || a_ready !== 1'b0)
            $display("FAIL core_rd m_we=%b m_addr=%h a_ready=%b want 0/0010/0", m_we, m_addr, a_ready);
        else passed++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++;
        if (c_dout !== 16'h1234) $display("FAIL core_rd_data got=%h want=1234", c_dout); else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (c_dout !== 16'h1234) $display("FAIL core_rd_hold got=%h want=1234", c_dout); else passed++;
        next_cycle();
    endtask

    task automatic test_aux_only();
        a_valid = 1; a_we = 1; a_addr = 16'h0020; a_din = 16'hBEEF;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1 || m_we !== 1'b1 || m_addr !== 16'h0020 || m_din !== 16'hBEEF)
            $display("FAIL aux_wr a_ready=%b m_we=%b m_addr=%h m_din=%h want 1/1/0020/beef",
                     a_ready, m_we, m_addr, m_din);
        else passed++;
        next_cycle();
        a_we = 0;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1 || a_rvalid !== 1'b0 || m_we !== 1'b0)
            $display("FAIL aux_rd a_ready=%b a_rvalid=%b m_we=%b want 1/0/0", a_ready, a_rvalid, m_we);
        else passed++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'hBEEF)
            $display("FAIL aux_rd_data a_rvalid=%b a_rdata=%h want 1/beef", a_rvalid, a_rdata);
        else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (a_rvalid !== 1'b0) $display("FAIL aux_rvalid_pulse got=%b want=0", a_rvalid); else passed++;
        next_cycle();
    endtask

    task automatic test_contention();
        int bad = 0;
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        a_valid = 1; a_we = 1; a_addr = 16'h0040; a_din = 16'h5555;
        for (int i = 0; i < int'(MAX_WAIT); i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || c_stall !== 1'b0) begin
                bad++;
                $display("FAIL contend_block cyc=%0d a_ready=%b c_stall=%b want 0/0",
                         i, a_ready, c_stall);
            end
            next_cycle();
        end
        total++;
        if (bad == 0) passed++;
`ifdef YD_DBUS_STARVE_EN
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1 || c_stall !== 1'b1 || m_we !== 1'b1 || m_addr !== 16'h0040)
            $display("FAIL force_grant a_ready=%b c_stall=%b m_we=%b m_addr=%h want 1/1/1/0040",
                     a_ready, c_stall, m_we, m_addr);
        else passed++;
        total++;
        if (c_dout !== 16'h1234) $display("FAIL stall_c_dout got=%h want=1234", c_dout); else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (c_stall !== 1'b0 || a_ready !== 1'b0 || m_addr !== 16'h0010)
            $display("FAIL after_force c_stall=%b a_ready=%b m_addr=%h want 0/0/0010",
                     c_stall, a_ready, m_addr);
        else passed++;
        total++;
        if (c_dout !== 16'h1234) $display("FAIL post_stall_c_dout got=%h want=1234", c_dout); else passed++;
        next_cycle();
`else
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_ready !== 1'b0 || c_stall !== 1'b0) begin
                bad++;
                $display("FAIL strict_prio cyc=%0d a_ready=%b c_stall=%b want 0/0",
                         i, a_ready, c_stall);
            end
            next_cycle();
        end
        total++;
        if (bad == 0) passed++;
        @(negedge clk);
        total++;
        if (c_dout !== 16'h1234) $display("FAIL contend_c_dout got=%h want=1234", c_dout); else passed++;
        next_cycle();
`endif
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_same_addr();
        c_req = 1; c_we = 1; c_addr = 16'h0030; c_din = 16'h0001;
        a_valid = 1; a_we = 0; a_addr = 16'h0030;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b0 || m_we !== 1'b1 || m_din !== 16'h0001)
            $display("FAIL race_core a_ready=%b m_we=%b m_din=%h want 0/1/0001", a_ready, m_we, m_din);
        else passed++;
        next_cycle();
        c_req = 0; c_we = 0;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1 || m_we !== 1'b0 || m_addr !== 16'h0030)
            $display("FAIL race_aux a_ready=%b m_we=%b m_addr=%h want 1/0/0030", a_ready, m_we, m_addr);
        else passed++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'h0001)
            $display("FAIL race_data a_rvalid=%b a_rdata=%h want 1/0001", a_rvalid, a_rdata);
        else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        a_valid = 1; a_we = 0; a_addr = 16'h0020;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1) $display("FAIL mid_grant a_ready=%b want 1", a_ready); else passed++;
        next_cycle();
        rst = 1;
        c_req = 1; c_we = 1; c_addr = 16'h0011; c_din = 16'hDEAD;
        @(negedge clk);
        total++;
        if (a_rvalid !== 1'b0 || m_we !== 1'b0 || a_ready !== 1'b0)
            $display("FAIL mid_rst a_rvalid=%b m_we=%b a_ready=%b want 0/0/0", a_rvalid, m_we, a_ready);
        else passed++;
        next_cycle();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        total++;
        if (a_rvalid !== 1'b0 || c_dout !== 16'h0000 || c_stall !== 1'b0 || m_addr !== 16'h0000)
            $display("FAIL post_rst a_rvalid=%b c_dout=%h c_stall=%b m_addr=%h want 0",
                     a_rvalid, c_dout, c_stall, m_addr);
        else passed++;
        next_cycle();
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++;
        if (c_dout !== 16'h1234) $display("FAIL post_rst_rd got=%h want=1234", c_dout); else passed++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_core_only();
        test_aux_only();
        test_contention();
        test_same_addr();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/yd_dbus_arbiter.md
# yd_dbus_arbiter

- Shares one synchronous single-port 16-bit data RAM between the YD core data bus and one auxiliary requester (loader/debug/DMA) using a valid/ready handshake.
- Sits between the core's d_* port and the data RAM.
- The core has priority; the auxiliary port uses idle core cycles.
- An optional starvation guard forces an auxiliary grant and stalls the core for that cycle.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_WAIT, 8, consecutive aux-blocked cycles before a forced grant (range 1-255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- c_req  in  1  core requests memory this cycle
- c_addr  in  AW  core address
- c_din  in  DW  core write data
- c_we  in  1  core write enable
- c_dout  out  DW  core read data
- c_stall  out  1  core must hold its request this cycle
- a_valid  in  1  aux request valid
- a_ready  out  1  aux request accepted this cycle
- a_addr  in  AW  aux address
- a_din  in  DW  aux write data
- a_we  in  1  aux write enable
- a_rvalid  out  1  aux read data valid
- a_rdata  out  DW  aux read data
- m_addr  out  AW  RAM address
- m_din  out  DW  RAM write data
- m_we  out  1  RAM write enable
- m_dout  in  DW  RAM read data, one cycle after address

## Operation
- **Grant decision (combinational, per cycle), in priority order:**
  - force: a_valid && wait_cnt==MAX_WAIT, only with the macro defined.
  - core: c_req.
  - aux: a_valid.
  - none: otherwise.
- **Outputs per grant:**
  - Core grant: m_* = c_*.
  - Aux or force grant: m_* = a_*, a_ready=1.
  - Force grant: c_stall=1.
  - None: m_we=0, m_addr=0, m_din=0.
- **last_grant register**, values NONE/CORE_RD/CORE_WR/AUX_RD/AUX_WR: records the type of the current grant, updated every cycle.
- **Read return:**
  - last_grant==CORE_RD: c_dout=m_dout, and c_dout_q<=m_dout. Otherwise c_dout=c_dout_q, so the core sees stable data across stalls.
  - last_grant==AUX_RD: a_rvalid=1 and a_rdata=m_dout for that one cycle. Otherwise a_rvalid=0; a_rdata is don't-care while a_rvalid=0.
- **wait_cnt:**
  - Increments, saturating at MAX_WAIT, each cycle a_valid && !a_ready.
  - Clears on any aux grant, and when a_valid=0.
- **Hazards:** aux and core accesses to the same address are serialized in grant order. There is no forwarding.

## Timing
- **Reset values:** c_stall=0, a_ready=0, a_rvalid=0, m_we=0, m_addr=0, m_din=0, c_dout=0, c_dout_q=0, wait_cnt=0, last_grant=NONE.
- **While rst=1:** m_we and a_ready are forced to 0 combinationally, the same cycle.
- **Latencies:**
  - Write: committed at the grant edge.
  - Read: data appears the cycle after the grant.
  - Aux throughput: at most 1 transaction per cycle when the core is idle.
- **Forced-grant sequence:** a_valid held with c_req=1 for MAX_WAIT cycles → cycle MAX_WAIT+1 is a forced grant with c_stall=1 → the next cycle reverts to core priority, with wait_cnt=0.
- **Reset mid-operation:** a pending a_rvalid is dropped; the aux transaction accepted in the cycle before rst has its write committed, but its read is lost.

## Configuration
- **YD_DBUS_STARVE_EN defined:** the starvation guard, wait_cnt and forced grants are present; c_stall follows the force rule.
- **YD_DBUS_STARVE_EN undefined:** strict core priority. wait_cnt is removed and c_stall is tied to 0, so the aux port can starve indefinitely.

## Structure
- **Shared package yd_pkg:**
  - last_grant enum (NONE, CORE_RD, CORE_WR, AUX_RD, AUX_WR).
  - YD_AW/YD_DW defaults of 16.
- **Sub-module yd_starve_cnt:** the saturating wait counter, emitting force = a_valid && cnt==MAX_WAIT. Instantiated only under YD_DBUS_STARVE_EN.

## Test plan
- Core only: write 0x1234 to 0x0010, then read 0x0010 → c_dout=0x1234 the cycle after the read grant; a_ready=0 throughout.
- Aux only with c_req=0: aux write 0xBEEF @0x0020, then aux read @0x0020 → a_ready=1 each cycle; a_rvalid=1 with a_rdata=0xBEEF one cycle after the read.
- Contention: c_req=1 continuously, a_valid=1, macro defined, MAX_WAIT=8 → a_ready=0 for 8 cycles; 9th cycle a_ready=1 and c_stall=1; next cycle c_stall=0. c_dout holds the last core read value during the stall.
- Same contention with the macro undefined → a_ready never asserts and c_stall stays 0.
- Same-address race: core write 0x0001 @0x0030 and aux read @0x0030 in the same cycle → core granted first; aux granted next idle cycle and returns 0x0001.
- Reset: assert rst during an aux read grant → next cycle a_rvalid=0, m_we=0, all outputs at reset values; first post-reset core read works normally.
